// File: rtl/conv_pkg.sv
// Shared definitions for the conv / pooling pipeline stages:
// FSM state codes, datapath width and the unsigned 8-bit saturation helper.
package conv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F0   = 3'd1;
  localparam logic [2:0] S_F1   = 3'd2;
  localparam logic [2:0] S_F2   = 3'd3;
  localparam logic [2:0] S_F3   = 3'd4;
  localparam logic [2:0] S_F4   = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  // Clamp a signed value into 0..255 (negative -> 0, above 255 -> 255).
  function automatic logic [7:0] sat_to_u8(input logic signed [DATA_W-1:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 32'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/relu_maxpool_sat_u8.sv
// Combinational clamp of a signed 32-bit value to the unsigned byte range.
module sat_u8
  import conv_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_value,
  output logic        [7:0]        o_byte
);

  assign o_byte = sat_to_u8(i_value);

endmodule

// File: rtl/relu_maxpool.sv
// 2x2 stride-2 max pooling followed by ReLU, arithmetic-shift requantisation
// and u8 saturation. Reads conv results through a registered-read port and
// stores packed bytes in a local output memory with a combinational read.
module relu_maxpool
  import conv_pkg::*;
#(
  parameter int DSIZE = 256,
  parameter int AW    = $clog2(DSIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_width,
  input  logic [7:0]               in_height,
  input  logic [4:0]               shift,
  input  logic                     start,
  output logic                     done,
  output logic [AW-1:0]            ci_addr,
  input  logic signed [DATA_W-1:0] ci_data,
  input  logic [AW-1:0]            mo_addr,
  output logic [DATA_W-1:0]        mo_data
);

  localparam int BW = $clog2(DSIZE);

  logic [2:0]               r_state;
  logic [2:0]               w_state_next;
  logic [7:0]               r_ox;
  logic [7:0]               r_oy;
  logic [7:0]               w_ox_next;
  logic [7:0]               w_oy_next;
  logic [7:0]               w_out_w;
  logic [7:0]               w_out_h;
  logic                     w_row_end;
  logic                     w_last;
  logic signed [DATA_W-1:0] r_max;
  logic signed [DATA_W-1:0] w_shifted;
  logic [7:0]               w_byte;
  logic [15:0]              r_pix;
  logic                     r_done;
  logic [AW-1:0]            r_ci_addr;
  logic [15:0]              w_row;
  logic [15:0]              w_col;

  // Control strobes decoded from the FSM
  logic                     w_start_op;
  logic                     w_load_first;
  logic                     w_update_max;
  logic                     w_write;
  logic                     w_drive_addr;
  logic                     w_dy;
  logic                     w_dx;

  logic [7:0]               r_mem [DSIZE];

  assign w_out_w   = in_width >> 1;
  assign w_out_h   = in_height >> 1;
  assign w_row_end = (r_ox == w_out_w - 8'd1);
  assign w_last    = w_row_end && (r_oy == w_out_h - 8'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state logic: five window cycles plus one write cycle per pixel
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_state_next = (w_out_w == 8'd0 || w_out_h == 8'd0) ? S_DONE : S_F0;
      end
      S_F0:   w_state_next = S_F1;
      S_F1:   w_state_next = S_F2;
      S_F2:   w_state_next = S_F3;
      S_F3:   w_state_next = S_F4;
      S_F4:   w_state_next = S_WR;
      S_WR:   w_state_next = w_last ? S_DONE : S_F0;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: datapath strobes and the window offset of the next fetch
  always_comb begin
    w_start_op   = (r_state == S_IDLE) && start;
    w_load_first = (r_state == S_F1);
    w_update_max = (r_state == S_F2) || (r_state == S_F3) || (r_state == S_F4);
    w_write      = (r_state == S_WR);
    w_drive_addr = (w_state_next == S_F0) || (w_state_next == S_F1) ||
                   (w_state_next == S_F2) || (w_state_next == S_F3);
    w_dy         = (w_state_next == S_F2) || (w_state_next == S_F3);
    w_dx         = (w_state_next == S_F1) || (w_state_next == S_F3);
  end

  // Pixel coordinate update: advance in WR, wrap at the row end
  always_comb begin
    w_ox_next = r_ox;
    w_oy_next = r_oy;
    if (w_start_op) begin
      w_ox_next = 8'd0;
      w_oy_next = 8'd0;
    end else if (w_write) begin
      if (w_row_end) begin
        w_ox_next = 8'd0;
        w_oy_next = r_oy + 8'd1;
      end else begin
        w_ox_next = r_ox + 8'd1;
      end
    end
  end

  // Input coordinates of the next fetch, in 16-bit arithmetic
  assign w_row = {7'd0, w_oy_next, 1'b0} + {15'd0, w_dy};
  assign w_col = {7'd0, w_ox_next, 1'b0} + {15'd0, w_dx};

  // Pixel counters and byte write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ox  <= 8'd0;
      r_oy  <= 8'd0;
      r_pix <= 16'd0;
    end else begin
      r_ox <= w_ox_next;
      r_oy <= w_oy_next;
      if (w_start_op)
        r_pix <= 16'd0;
      else if (w_write)
        r_pix <= r_pix + 16'd1;
    end
  end

  // Conv read address: loaded as each window fetch state is entered, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ci_addr <= '0;
    else if (w_drive_addr)
      r_ci_addr <= AW'(w_row * {8'd0, in_width} + w_col);
  end

  // Running signed maximum over the four window samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_max <= '0;
    else if (w_load_first)
      r_max <= ci_data;
    else if (w_update_max && (ci_data > r_max))
      r_max <= ci_data;
  end

  // Completion flag: cleared on an accepted start, set when leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_done <= 1'b0;
    else if (w_start_op)
      r_done <= 1'b0;
    else if (r_state == S_DONE)
      r_done <= 1'b1;
  end

  // Requantise; ReLU and the upper clamp both fall out of the u8 saturation
  assign w_shifted = r_max >>> shift;

  sat_u8 u_sat (
    .i_value (w_shifted),
    .o_byte  (w_byte)
  );

  // Output memory write, one byte per pooled pixel; contents survive reset
  always_ff @(posedge clk) begin
    if (w_write && (r_pix < 16'(DSIZE)))
      r_mem[r_pix[BW-1:0]] <= w_byte;
  end

  // Combinational word read; addresses past the array read as zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    logic [AW-1:0] w_baddr;
    assign w_baddr = (mo_addr & ~AW'(3)) | AW'(gi);
    assign mo_data[8*gi +: 8] = (w_baddr < AW'(DSIZE)) ? r_mem[w_baddr[BW-1:0]] : 8'd0;
  end

  assign done    = r_done;
  assign ci_addr = r_ci_addr;

endmodule
